// File: rtl/led_pkg.sv
// led_pkg: shared mode/direction encodings and small helpers for the LED controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Config macro: LED_BLINK_EN selects whether BLINK is part of the mode cycle.
package led_pkg;

  localparam int LED_N = 3;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_FLOW   = 2'd2
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Mode sequence on each mode-key press. Without blink support the
  // cycle skips BLINK entirely, so encoding 1 is never reached.
  function automatic mode_e next_mode(input mode_e m);
`ifdef LED_BLINK_EN
    case (m)
      MODE_MANUAL: next_mode = MODE_BLINK;
      MODE_BLINK:  next_mode = MODE_FLOW;
      default:     next_mode = MODE_MANUAL;
    endcase
`else
    case (m)
      MODE_MANUAL: next_mode = MODE_FLOW;
      default:     next_mode = MODE_MANUAL;
    endcase
`endif
  endfunction

  // One-hot rotation: left 001->010->100, right 001->100->010.
  function automatic logic [LED_N-1:0] rotate(input logic [LED_N-1:0] p, input logic dir);
    if (dir == DIR_LEFT) rotate = {p[LED_N-2:0], p[LED_N-1]};
    else                 rotate = {p[0], p[LED_N-1:1]};
  endfunction

endpackage

// File: rtl/led_tick.sv
// led_tick: free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is decoded from the counter register; clr restarts the period at 0.
// Backpressure: none; tick is a pulse and is never held.
// Ports: clk, rst (async, active-high), clr (sync restart), tick (cnt == TICK_DIV-1).
module led_tick #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: mode-driven LED pattern controller (manual toggle, blink, running light).
// Latency: key pulses and ticks reach led/mode at the edge that samples them (registered outputs).
// Backpressure: none; press pulses are consumed in the cycle they arrive.
// Ports: clk, rst (async, active-high), key_led[2:0], key_mode -> led[2:0], mode[1:0].
// Config macro: LED_BLINK_EN includes BLINK mode (phase, blink_mask); undefined compiles it out.
module led_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_N-1:0] key_led,
  input  logic             key_mode,
  output logic [LED_N-1:0] led,
  output logic [1:0]       mode
);

  mode_e            mode_q, mode_n;
  logic [LED_N-1:0] man_led, man_led_n;
  logic [LED_N-1:0] pos, pos_n;
  logic             dir, dir_n;
  logic             run, run_n;
  logic [LED_N-1:0] led_q, led_n;
  logic             tick;
`ifdef LED_BLINK_EN
  logic [LED_N-1:0] blink_mask, blink_mask_n;
  logic             phase, phase_n;
`endif

  // Every mode change restarts the pattern period from zero.
  led_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (key_mode),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_MANUAL;
      man_led    <= '0;
      pos        <= LED_N'(1);
      dir        <= DIR_LEFT;
      run        <= 1'b1;
      led_q      <= '0;
`ifdef LED_BLINK_EN
      blink_mask <= '1;
      phase      <= 1'b1;
`endif
    end else begin
      mode_q     <= mode_n;
      man_led    <= man_led_n;
      pos        <= pos_n;
      dir        <= dir_n;
      run        <= run_n;
      led_q      <= led_n;
`ifdef LED_BLINK_EN
      blink_mask <= blink_mask_n;
      phase      <= phase_n;
`endif
    end
  end

  always_comb begin
    mode_n       = mode_q;
    man_led_n    = man_led;
    pos_n        = pos;
    dir_n        = dir;
    run_n        = run;
    led_n        = '0;
`ifdef LED_BLINK_EN
    blink_mask_n = blink_mask;
    phase_n      = phase;
`endif

    if (key_mode) begin
      // Mode change takes priority: LED keys and the tick are dropped this cycle.
      mode_n = next_mode(mode_q);
      case (mode_n)
`ifdef LED_BLINK_EN
        MODE_BLINK: phase_n = 1'b1;
`endif
        MODE_FLOW: begin
          pos_n = LED_N'(1);
          dir_n = DIR_LEFT;
          run_n = 1'b1;
        end
        default: ;
      endcase
    end else begin
      case (mode_q)
        MODE_MANUAL: man_led_n = man_led ^ key_led;
`ifdef LED_BLINK_EN
        MODE_BLINK: begin
          blink_mask_n = blink_mask ^ key_led;
          if (tick) phase_n = ~phase;
        end
`endif
        MODE_FLOW: begin
          // Both direction keys together cancel out and leave dir alone.
          if (key_led[0] && !key_led[1]) dir_n = DIR_LEFT;
          if (key_led[1] && !key_led[0]) dir_n = DIR_RIGHT;
          run_n = run ^ key_led[2];
          // A same-cycle direction press steers this rotation; a same-cycle
          // run toggle only affects later ticks, hence the old run here.
          if (tick && run) pos_n = rotate(pos, dir_n);
        end
        default: ;
      endcase
    end

    case (mode_n)
      MODE_MANUAL: led_n = man_led_n;
`ifdef LED_BLINK_EN
      MODE_BLINK:  led_n = blink_mask_n & {LED_N{phase_n}};
`endif
      MODE_FLOW:   led_n = pos_n;
      default:     led_n = '0;
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
